// File: rtl/blob_bbox_tracker_if.sv
// blob_bbox_tracker_if: video-in, forwarded video-out and per-frame result bundle for blob_bbox_tracker.
interface blob_bbox_tracker_if #(
  parameter int X_WIDTH   = 10,
  parameter int Y_WIDTH   = 10,
  parameter int CNT_WIDTH = 20
);
  logic [7:0]           iY;
  logic                 iHSync;
  logic                 iVSync;
  logic                 iLineValid;
  logic                 iFrameValid;
  logic [7:0]           oY;
  logic                 oHSync;
  logic                 oVSync;
  logic                 oLineValid;
  logic                 oFrameValid;
  logic [X_WIDTH-1:0]   oXMin;
  logic [X_WIDTH-1:0]   oXMax;
  logic [Y_WIDTH-1:0]   oYMin;
  logic [Y_WIDTH-1:0]   oYMax;
  logic [CNT_WIDTH-1:0] oCount;
  logic                 oEmpty;
  logic                 oValid;
  modport master (
    output iY, iHSync, iVSync, iLineValid, iFrameValid,
    input  oY, oHSync, oVSync, oLineValid, oFrameValid,
    input  oXMin, oXMax, oYMin, oYMax, oCount, oEmpty, oValid
  );
  modport slave (
    input  iY, iHSync, iVSync, iLineValid, iFrameValid,
    output oY, oHSync, oVSync, oLineValid, oFrameValid,
    output oXMin, oXMax, oYMin, oYMax, oCount, oEmpty, oValid
  );
endinterface

// File: rtl/blob_bbox_tracker.sv
// blob_bbox_tracker: per-frame foreground bounding box and pixel count, video forwarded one cycle late.
// Define BLOB_BBOX_OVERLAY_EN to draw the previous frame's box onto the forwarded luma.
module blob_bbox_tracker #(
  parameter int X_WIDTH       = 10,
  parameter int Y_WIDTH       = 10,
  parameter int CNT_WIDTH     = 20,
  parameter int THRESHOLD     = 255,
  parameter int OVERLAY_VALUE = 128
) (
  input logic                iClk,
  input logic                iRst,
  blob_bbox_tracker_if.slave bus
);
  typedef enum logic [1:0] {WAIT_FRAME, IN_FRAME, REPORT} state_t;
  state_t state_q;
  logic fv_q, lv_q, pix, fg, fv_rise, fv_fall, lv_fall, init, track, upd, report;
  logic [X_WIDTH-1:0] col_q, col_d, xmin_q, xmin_d, xmax_q, xmax_d, bxmin, bxmax, oxmin_q, oxmax_q;
  logic [Y_WIDTH-1:0] row_q, row_d, row_cur, ymin_q, ymin_d, ymax_q, ymax_d, bymin, bymax, oymin_q, oymax_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, bcnt, ocnt_q;
  logic [7:0] luma_q, luma_d;
  logic hs_q, vs_q, lvo_q, fvo_q, empty_q, valid_q;
  always_comb begin
    pix     = bus.iLineValid && bus.iFrameValid;
    fg      = pix && bus.iY >= 8'(THRESHOLD);
    fv_rise = bus.iFrameValid && !fv_q;
    fv_fall = !bus.iFrameValid && fv_q;
    lv_fall = !bus.iLineValid && lv_q;
    row_cur = fv_rise ? '0 : row_q;
    init    = fv_rise && state_q != IN_FRAME;
    track   = init || state_q == IN_FRAME;
    report  = state_q == IN_FRAME && fv_fall;
    bxmin   = init ? '1 : xmin_q;
    bxmax   = init ? '0 : xmax_q;
    bymin   = init ? '1 : ymin_q;
    bymax   = init ? '0 : ymax_q;
    bcnt    = init ? '0 : cnt_q;
    upd     = track && fg;
    xmin_d  = upd && col_q < bxmin ? col_q : bxmin;
    xmax_d  = upd && col_q > bxmax ? col_q : bxmax;
    ymin_d  = upd && row_cur < bymin ? row_cur : bymin;
    ymax_d  = upd && row_cur > bymax ? row_cur : bymax;
    cnt_d   = upd && bcnt != '1 ? bcnt + 1'b1 : bcnt;
    col_d   = !bus.iLineValid ? '0 : pix && col_q != '1 ? col_q + 1'b1 : col_q;
    row_d   = fv_rise ? '0 : lv_fall && bus.iFrameValid && row_q != '1 ? row_q + 1'b1 : row_q;
  end
`ifdef BLOB_BBOX_OVERLAY_EN
  logic on_x, on_y, in_x, in_y;
  // compare against the published box, so the drawn rectangle lags one frame
  always_comb begin
    on_x   = col_q == oxmin_q || col_q == oxmax_q;
    on_y   = row_cur == oymin_q || row_cur == oymax_q;
    in_x   = col_q >= oxmin_q && col_q <= oxmax_q;
    in_y   = row_cur >= oymin_q && row_cur <= oymax_q;
    luma_d = pix && !empty_q && (on_x && in_y || on_y && in_x) ? 8'(OVERLAY_VALUE) : bus.iY;
  end
`else
  assign luma_d = bus.iY;
`endif
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= WAIT_FRAME;
      fv_q    <= bus.iFrameValid;
      lv_q    <= bus.iLineValid;
      col_q   <= '0;
      row_q   <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cnt_q   <= '0;
      oxmin_q <= '0;
      oxmax_q <= '0;
      oymin_q <= '0;
      oymax_q <= '0;
      ocnt_q  <= '0;
      empty_q <= 1'b1;
      valid_q <= 1'b0;
      luma_q  <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      lvo_q   <= 1'b0;
      fvo_q   <= 1'b0;
    end else begin
      fv_q    <= bus.iFrameValid;
      lv_q    <= bus.iLineValid;
      col_q   <= col_d;
      row_q   <= row_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cnt_q   <= cnt_d;
      luma_q  <= luma_d;
      hs_q    <= bus.iHSync;
      vs_q    <= bus.iVSync;
      lvo_q   <= bus.iLineValid;
      fvo_q   <= bus.iFrameValid;
      valid_q <= report;
      if (report) begin
        empty_q <= cnt_q == '0;
        oxmin_q <= cnt_q == '0 ? '0 : xmin_q;
        oxmax_q <= cnt_q == '0 ? '0 : xmax_q;
        oymin_q <= cnt_q == '0 ? '0 : ymin_q;
        oymax_q <= cnt_q == '0 ? '0 : ymax_q;
        ocnt_q  <= cnt_q;
      end
      case (state_q)
        WAIT_FRAME: state_q <= fv_rise ? IN_FRAME : WAIT_FRAME;
        IN_FRAME:   state_q <= fv_fall ? REPORT : IN_FRAME;
        default:    state_q <= bus.iFrameValid ? IN_FRAME : WAIT_FRAME;
      endcase
    end
  end
  assign bus.oY          = luma_q;
  assign bus.oHSync      = hs_q;
  assign bus.oVSync      = vs_q;
  assign bus.oLineValid  = lvo_q;
  assign bus.oFrameValid = fvo_q;
  assign bus.oXMin       = oxmin_q;
  assign bus.oXMax       = oxmax_q;
  assign bus.oYMin       = oymin_q;
  assign bus.oYMax       = oymax_q;
  assign bus.oCount      = ocnt_q;
  assign bus.oEmpty      = empty_q;
  assign bus.oValid      = valid_q;
endmodule

// File: tb/tb_blob_bbox_tracker.sv
// tb_blob_bbox_tracker: directed frames; expected reports queued at frame end, popped by a monitor on oValid.
module tb_blob_bbox_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  blob_bbox_tracker_if #(.X_WIDTH(10), .Y_WIDTH(10), .CNT_WIDTH(20)) bus ();
  blob_bbox_tracker dut (.iClk(clk), .iRst(rst), .bus(bus));
`ifdef BLOB_BBOX_OVERLAY_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  typedef struct {int xmin; int xmax; int ymin; int ymax; int cnt; bit empty; int cyc;} rep_t;
  typedef struct {int x; int y; logic [7:0] v;} fg_t;
  rep_t sb[$];
  fg_t fg[$];
  rep_t mr;
  int errors = 0, checks = 0, cyc = 0;
  bit vchk = 1'b0, box_on = 1'b0;
  int bx0, bx1, by0, by1;
  logic [7:0] exp_y = '0;
  logic exp_hs = 1'b0, exp_vs = 1'b0, exp_lv = 1'b0, exp_fv = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [7:0] pval(input int x, input int y);
    foreach (fg[i]) if (fg[i].x == x && fg[i].y == y) return fg[i].v;
    return 8'd0;
  endfunction
  function automatic bit on_border(input int x, input int y);
    return ((x == bx0 || x == bx1) && y >= by0 && y <= by1) || ((y == by0 || y == by1) && x >= bx0 && x <= bx1);
  endfunction
  task automatic set_in(input logic [7:0] y, input logic lv, input logic fv);
    bus.iY = y;
    bus.iLineValid = lv;
    bus.iFrameValid = fv;
    bus.iHSync = ~lv;
    bus.iVSync = ~fv;
  endtask
  task automatic drive(input logic [7:0] y, input logic lv, input logic fv, input bit border);
    set_in(y, lv, fv);
    @(posedge clk);
    #1;
    exp_y  = (OVL && box_on && border && lv && fv) ? 8'd128 : y;
    exp_hs = ~lv;
    exp_vs = ~fv;
    exp_lv = lv;
    exp_fv = fv;
  endtask
  task automatic do_reset(input logic [7:0] y, input logic lv, input logic fv);
    rst = 1'b1;
    set_in(y, lv, fv);
    @(posedge clk);
    #1;
    chk("rst_xmin", bus.oXMin, 0);
    chk("rst_xmax", bus.oXMax, 0);
    chk("rst_ymin", bus.oYMin, 0);
    chk("rst_ymax", bus.oYMax, 0);
    chk("rst_count", bus.oCount, 0);
    chk("rst_empty", bus.oEmpty, 1);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_video", {bus.oY, bus.oHSync, bus.oVSync, bus.oLineValid, bus.oFrameValid}, 0);
    {exp_y, exp_hs, exp_vs, exp_lv, exp_fv} = '0;
    box_on = 1'b0;
    vchk = 1'b1;
    rst = 1'b0;
  endtask
  task automatic frame(input int w, input int h, input bit short_rows, input rep_t e);
    drive(0, 0, 1, 0);
    for (int y = 0; y < h; y++) begin
      int rw;
      rw = (short_rows && y < h - 1) ? 1 : w;
      for (int x = 0; x < rw; x++) drive(pval(x, y), 1, 1, on_border(x, y));
      if (y < h - 1) drive(0, 0, 1, 0);
    end
    e.cyc = cyc + 1;
    sb.push_back(e);
    drive(0, 0, 0, 0);
    box_on = !e.empty;
    bx0 = e.xmin;
    bx1 = e.xmax;
    by0 = e.ymin;
    by1 = e.ymax;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && vchk) begin
      chk("video", {bus.oY, bus.oHSync, bus.oVSync, bus.oLineValid, bus.oFrameValid},
          {exp_y, exp_hs, exp_vs, exp_lv, exp_fv});
      if (bus.oValid !== 1'b0) begin
        if (sb.size() == 0) chk("unexpected_valid", bus.oValid, 0);
        else begin
          mr = sb.pop_front();
          chk("report_cycle", cyc, mr.cyc);
          chk("xmin", bus.oXMin, mr.xmin);
          chk("xmax", bus.oXMax, mr.xmax);
          chk("ymin", bus.oYMin, mr.ymin);
          chk("ymax", bus.oYMax, mr.ymax);
          chk("count", bus.oCount, mr.cnt);
          chk("empty", bus.oEmpty, mr.empty);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
  initial begin
    set_in(0, 0, 0);
    do_reset(0, 0, 0);
    idle(3);
    fg.delete();
    fg.push_back(fg_t'{3, 2, 8'd255});
    frame(8, 4, 0, rep_t'{3, 3, 2, 2, 1, 1'b0, 0});
    idle(2);
    fg.delete();
    frame(8, 4, 0, rep_t'{0, 0, 0, 0, 0, 1'b1, 0});
    idle(2);
    fg.push_back(fg_t'{0, 0, 8'd255});
    fg.push_back(fg_t'{799, 599, 8'd255});
    frame(800, 600, 1, rep_t'{0, 799, 0, 599, 2, 1'b0, 0});
    fg.delete();
    frame(8, 4, 0, rep_t'{0, 0, 0, 0, 0, 1'b1, 0});
    idle(2);
    fg.push_back(fg_t'{2, 1, 8'd255});
    drive(0, 0, 1, 0);
    for (int x = 0; x < 8; x++) drive(pval(x, 0), 1, 1, on_border(x, 0));
    drive(0, 0, 1, 0);
    for (int x = 0; x < 3; x++) drive(pval(x, 1), 1, 1, on_border(x, 1));
    do_reset(255, 1, 1);
    for (int x = 0; x < 4; x++) drive(255, 1, 1, 0);
    drive(0, 0, 1, 0);
    drive(255, 1, 1, 0);
    drive(0, 0, 0, 0);
    idle(3);
    fg.delete();
    fg.push_back(fg_t'{3, 2, 8'd255});
    fg.push_back(fg_t'{6, 1, 8'd255});
    frame(8, 4, 0, rep_t'{3, 6, 1, 2, 2, 1'b0, 0});
    idle(1);
    fg.delete();
    fg.push_back(fg_t'{1, 1, 8'd254});
    fg.push_back(fg_t'{6, 0, 8'd255});
    frame(8, 4, 0, rep_t'{6, 6, 0, 0, 1, 1'b0, 0});
    fg.delete();
    fg.push_back(fg_t'{0, 3, 8'd255});
    fg.push_back(fg_t'{7, 1, 8'd255});
    fg.push_back(fg_t'{4, 2, 8'd255});
    frame(8, 4, 0, rep_t'{0, 7, 1, 3, 3, 1'b0, 0});
    idle(2);
    fg.delete();
    fg.push_back(fg_t'{2, 1, 8'd255});
    fg.push_back(fg_t'{5, 3, 8'd255});
    frame(8, 5, 0, rep_t'{2, 5, 1, 3, 2, 1'b0, 0});
    fg.delete();
    frame(8, 5, 0, rep_t'{0, 0, 0, 0, 0, 1'b1, 0});
    idle(4);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
